// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 VGA timing constants and region helper
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_CLK_DIV   = 4;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;   // exclusive
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;   // exclusive

    typedef logic [CNT_W-1:0] cnt_t;

    // True when lo <= c < hi.
    function automatic logic in_window(input cnt_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - CLK_DIV clock-enable divider producing the pixel tick
//   clk, rst_n : board clock, asynchronous active-low reset
//   tick_en    : combinational, high on the clock whose edge wraps the divider
//   pixel_tick : registered copy of tick_en, aligned with the counter update
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_en,
    output logic pixel_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // With CLK_DIV = 1 the divider is stuck at 0 and tick_en is always high.
    assign tick_en = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            pixel_tick <= 1'b0;
        end else begin
            div        <= tick_en ? '0 : div + DIV_W'(1);
            pixel_tick <= tick_en;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/bright decode and frame pulse
//   clk, reset         : board clock, asynchronous active-low reset
//   pixel_tick         : one-clk pulse on each counter advance
//   hCount, vCount     : current raster position
//   bright             : current position is inside the visible area
//   hSync, vSync       : active-low sync pins
//   frame_start        : one-clk pulse when the counters wrap to (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             bright,
    output logic             hSync,
    output logic             vSync,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic tick_en;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clk       (clk),
        .rst_n     (reset),
        .tick_en   (tick_en),
        .pixel_tick(pixel_tick)
    );

    cnt_t h_next;
    cnt_t v_next;
    logic h_wrap;

    always_comb begin
        h_wrap = (hCount == cnt_t'(H_TOTAL - 1));
        h_next = h_wrap ? '0 : hCount + cnt_t'(1);
        v_next = vCount;
        if (h_wrap) begin
            v_next = (vCount == cnt_t'(V_TOTAL - 1)) ? '0 : vCount + cnt_t'(1);
        end
    end

    // Decode is taken from the next counter values so the registered flags
    // always describe the position presented alongside them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hCount      <= cnt_t'(H_TOTAL - 1);
            vCount      <= cnt_t'(V_TOTAL - 1);
            bright      <= 1'b0;
            hSync       <= 1'b1;
            vSync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick_en) begin
                hCount      <= h_next;
                vCount      <= v_next;
                bright      <= in_window(h_next, 0, H_VISIBLE) && in_window(v_next, 0, V_VISIBLE);
                hSync       <= !in_window(h_next, HS_START, HS_END);
                vSync       <= !in_window(v_next, VS_START, VS_END);
                frame_start <= (h_next == '0) && (v_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic chk_on = 1'b0;

    // A: default timing, CLK_DIV = 4
    logic       a_tick, a_bright, a_hs, a_vs, a_fs;
    logic [9:0] a_h, a_v;
    // B: CLK_DIV = 1, short 10-pixel lines, default vertical timing
    logic       b_tick, b_bright, b_hs, b_vs, b_fs;
    logic [9:0] b_h, b_v;
    // C: CLK_DIV = 1, default timing
    logic       c_tick, c_bright, c_hs, c_vs, c_fs;
    logic [9:0] c_h, c_v;

    vga_timing_gen u_a (
        .clk(clk), .reset(rst_n), .pixel_tick(a_tick), .hCount(a_h), .vCount(a_v),
        .bright(a_bright), .hSync(a_hs), .vSync(a_vs), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(1)
    ) u_b (
        .clk(clk), .reset(rst_n), .pixel_tick(b_tick), .hCount(b_h), .vCount(b_v),
        .bright(b_bright), .hSync(b_hs), .vSync(b_vs), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1)
    ) u_c (
        .clk(clk), .reset(rst_n), .pixel_tick(c_tick), .hCount(c_h), .vCount(c_v),
        .bright(c_bright), .hSync(c_hs), .vSync(c_vs), .frame_start(c_fs)
    );

    function automatic logic [2:0] decode(input int h, input int v, input int hv, input int hf,
                                          input int hs, input int vv, input int vf, input int vs);
        logic b, hy, vy;
        b  = (h < hv) && (v < vv);
        hy = !((h >= hv + hf) && (h < hv + hf + hs));
        vy = !((v >= vv + vf) && (v < vv + vf + vs));
        return {b, hy, vy};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            checks += 3;
            if ({a_bright, a_hs, a_vs} !== decode(a_h, a_v, 640, 16, 96, 480, 10, 2)) begin
                errors++;
                $display("FAIL consistency_a h=%0d v=%0d got=%b exp=%b", a_h, a_v,
                         {a_bright, a_hs, a_vs}, decode(a_h, a_v, 640, 16, 96, 480, 10, 2));
            end
            if ({b_bright, b_hs, b_vs} !== decode(b_h, b_v, 4, 2, 3, 480, 10, 2)) begin
                errors++;
                $display("FAIL consistency_b h=%0d v=%0d got=%b exp=%b", b_h, b_v,
                         {b_bright, b_hs, b_vs}, decode(b_h, b_v, 4, 2, 3, 480, 10, 2));
            end
            if ({c_bright, c_hs, c_vs} !== decode(c_h, c_v, 640, 16, 96, 480, 10, 2)) begin
                errors++;
                $display("FAIL consistency_c h=%0d v=%0d got=%b exp=%b", c_h, c_v,
                         {c_bright, c_hs, c_vs}, decode(c_h, c_v, 640, 16, 96, 480, 10, 2));
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        chk_on = 1'b1;
        checks++;
        if ({a_h, a_v, a_bright, a_hs, a_vs, a_tick, a_fs} !== {10'd799, 10'd524, 5'b01100}) begin
            errors++;
            $display("FAIL reset_a got h=%0d v=%0d flags=%b exp h=799 v=524 flags=01100",
                     a_h, a_v, {a_bright, a_hs, a_vs, a_tick, a_fs});
        end
        checks++;
        if ({b_h, b_v, b_bright, b_hs, b_vs, b_tick, b_fs} !== {10'd9, 10'd524, 5'b01100}) begin
            errors++;
            $display("FAIL reset_b got h=%0d v=%0d flags=%b exp h=9 v=524 flags=01100",
                     b_h, b_v, {b_bright, b_hs, b_vs, b_tick, b_fs});
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a_h, a_v, a_bright, a_hs, a_vs, a_tick, a_fs} !== {10'd799, 10'd524, 5'b01100}) begin
                errors++;
                $display("FAIL release_hold_a edge=%0d got h=%0d v=%0d flags=%b exp h=799 v=524 flags=01100",
                         i, a_h, a_v, {a_bright, a_hs, a_vs, a_tick, a_fs});
            end
            if (i == 1) begin
                checks++;
                if ({b_h, b_v, b_bright, b_tick, b_fs} !== {10'd0, 10'd0, 3'b111}) begin
                    errors++;
                    $display("FAIL release_b got h=%0d v=%0d bright/tick/fs=%b exp 0 0 111",
                             b_h, b_v, {b_bright, b_tick, b_fs});
                end
                checks++;
                if ({c_h, c_v, c_bright, c_tick, c_fs} !== {10'd0, 10'd0, 3'b111}) begin
                    errors++;
                    $display("FAIL release_c got h=%0d v=%0d bright/tick/fs=%b exp 0 0 111",
                             c_h, c_v, {c_bright, c_tick, c_fs});
                end
            end
            if (i == 2) begin
                checks++;
                if (b_fs !== 1'b0) begin
                    errors++;
                    $display("FAIL release_b_fs_pulse got=%b exp=0", b_fs);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({a_h, a_v, a_bright, a_tick, a_fs} !== {10'd0, 10'd0, 3'b111}) begin
            errors++;
            $display("FAIL release_first_tick_a got h=%0d v=%0d bright/tick/fs=%b exp 0 0 111",
                     a_h, a_v, {a_bright, a_tick, a_fs});
        end
        @(negedge clk);
        checks++;
        if ({a_h, a_tick, a_fs} !== {10'd0, 2'b00}) begin
            errors++;
            $display("FAIL release_pulse_width_a got h=%0d tick/fs=%b exp h=0 tick/fs=00",
                     a_h, {a_tick, a_fs});
        end
    endtask

    task automatic test_hsync_line;
        int   lo_clk = 0, ticks = 0, vchg = 0;
        int   lo_first = -1, lo_end = -1, bright_fall = -1, vchg_prev_h = -1, vchg_h = -1, vchg_v = -1;
        logic p_hs = a_hs, p_bright = a_bright;
        int   p_h = a_h, p_v = a_v;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (a_hs === 1'b0) lo_clk++;
            if (a_tick === 1'b1) ticks++;
            if (p_hs === 1'b1 && a_hs === 1'b0) lo_first = a_h;
            if (p_hs === 1'b0 && a_hs === 1'b1) lo_end = a_h;
            if (p_bright === 1'b1 && a_bright === 1'b0) bright_fall = a_h;
            if (int'(a_v) != p_v) begin
                vchg++;
                vchg_prev_h = p_h;
                vchg_h = a_h;
                vchg_v = a_v;
            end
            p_hs = a_hs; p_bright = a_bright; p_h = a_h; p_v = a_v;
        end
        checks++;
        if (lo_clk != 384) begin errors++; $display("FAIL hsync_low_clk got=%0d exp=384", lo_clk); end
        checks++;
        if (lo_first != 656 || lo_end != 752) begin
            errors++;
            $display("FAIL hsync_window got start=%0d end=%0d exp start=656 end=752", lo_first, lo_end);
        end
        checks++;
        if (bright_fall != 640) begin errors++; $display("FAIL bright_fall_h got=%0d exp=640", bright_fall); end
        checks++;
        if (vchg != 1 || vchg_prev_h != 799 || vchg_h != 0 || vchg_v != 1) begin
            errors++;
            $display("FAIL vcount_step got n=%0d from_h=%0d to_h=%0d v=%0d exp n=1 799->0 v=1",
                     vchg, vchg_prev_h, vchg_h, vchg_v);
        end
        checks++;
        if (ticks != 800) begin errors++; $display("FAIL line_ticks got=%0d exp=800", ticks); end
    endtask

    task automatic test_frame;
        int n = 0, vs_lo = 0, br = 0, tick_lo = 0, vs_first = -1;
        logic p_vs;
        while (b_fs !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
        checks++;
        if (b_fs !== 1'b1) begin errors++; $display("FAIL frame_wait got=timeout exp=frame_start"); return; end
        n = 0;
        p_vs = b_vs;
        do begin
            if (b_vs === 1'b0) vs_lo++;
            if (p_vs === 1'b1 && b_vs === 1'b0) vs_first = b_v;
            if (b_bright === 1'b1) br++;
            if (b_tick !== 1'b1) tick_lo++;
            p_vs = b_vs;
            @(negedge clk);
            n++;
        end while (b_fs !== 1'b1 && n < 6000);
        checks++;
        if (n != 5250) begin errors++; $display("FAIL frame_period got=%0d exp=5250", n); end
        checks++;
        if (vs_lo != 20 || vs_first != 490) begin
            errors++;
            $display("FAIL vsync_window got clk=%0d start_v=%0d exp clk=20 start_v=490", vs_lo, vs_first);
        end
        checks++;
        if (br != 1920) begin errors++; $display("FAIL frame_bright_clk got=%0d exp=1920", br); end
        checks++;
        if (tick_lo != 0) begin errors++; $display("FAIL div1_tick_low got=%0d exp=0", tick_lo); end
    endtask

    task automatic test_div1_line;
        int n = 0, hs_lo = 0, hs_first = -1, tick_lo = 0;
        logic p_hs;
        while (c_h !== 10'd0 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (c_h !== 10'd0) begin errors++; $display("FAIL div1_line_wait got=timeout exp=h0"); return; end
        n = 0;
        p_hs = c_hs;
        do begin
            if (c_hs === 1'b0) hs_lo++;
            if (p_hs === 1'b1 && c_hs === 1'b0) hs_first = c_h;
            if (c_tick !== 1'b1) tick_lo++;
            p_hs = c_hs;
            @(negedge clk);
            n++;
        end while (c_h !== 10'd0 && n < 1000);
        checks++;
        if (n != 800) begin errors++; $display("FAIL div1_line_period got=%0d exp=800", n); end
        checks++;
        if (hs_lo != 96 || hs_first != 656) begin
            errors++;
            $display("FAIL div1_hsync got clk=%0d start=%0d exp clk=96 start=656", hs_lo, hs_first);
        end
        checks++;
        if (tick_lo != 0) begin errors++; $display("FAIL div1_line_tick_low got=%0d exp=0", tick_lo); end
    endtask

    task automatic test_mid_reset;
        int n = 0;
        while (!(b_h === 10'd3 && b_v === 10'd200) && n < 6000) begin @(negedge clk); n++; end
        checks++;
        if (!(b_h === 10'd3 && b_v === 10'd200)) begin
            errors++;
            $display("FAIL midreset_wait got=timeout exp=(3,200)");
            return;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b_h, b_v, b_bright, b_hs, b_vs, b_tick, b_fs} !== {10'd9, 10'd524, 5'b01100}) begin
            errors++;
            $display("FAIL midreset_async_b got h=%0d v=%0d flags=%b exp h=9 v=524 flags=01100",
                     b_h, b_v, {b_bright, b_hs, b_vs, b_tick, b_fs});
        end
        checks++;
        if ({a_h, a_v, a_bright, a_hs, a_vs, a_tick, a_fs} !== {10'd799, 10'd524, 5'b01100}) begin
            errors++;
            $display("FAIL midreset_async_a got h=%0d v=%0d flags=%b exp h=799 v=524 flags=01100",
                     a_h, a_v, {a_bright, a_hs, a_vs, a_tick, a_fs});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_h, b_v, b_fs, a_h, a_v} !== {10'd0, 10'd0, 1'b1, 10'd799, 10'd524}) begin
            errors++;
            $display("FAIL midreset_edge1 got b=(%0d,%0d) b_fs=%b a=(%0d,%0d) exp b=(0,0) b_fs=1 a=(799,524)",
                     b_h, b_v, b_fs, a_h, a_v);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({a_h, a_v, a_fs} !== {10'd799, 10'd524, 1'b0}) begin
            errors++;
            $display("FAIL midreset_hold_a got h=%0d v=%0d fs=%b exp 799 524 0", a_h, a_v, a_fs);
        end
        @(negedge clk);
        checks++;
        if ({a_h, a_v, a_bright, a_fs} !== {10'd0, 10'd0, 2'b11}) begin
            errors++;
            $display("FAIL midreset_restart_a got h=%0d v=%0d bright/fs=%b exp 0 0 11",
                     a_h, a_v, {a_bright, a_fs});
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_hsync_line();
        test_frame();
        test_div1_line();
        test_mid_reset();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz board clock. It produces the active-low `hSync` and `vSync` pins, the `bright` visible-area flag, and the `hCount`/`vCount` pixel coordinates consumed by `vga_bitchange`. It sits directly upstream of `vga_bitchange`, and of any sprite or overlay stage that keys off the raster position. All outputs are registered and mutually consistent on every clock.

## Interface
- `CLK_DIV`, 4: board clocks per pixel (100 MHz to 25 MHz); must be ≥1.
- `H_VISIBLE`, 640 / `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal segment lengths in pixels.
- `V_VISIBLE`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical segment lengths in lines.
- `clk` input 1: board clock, 100 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `pixel_tick` output 1: one-`clk` pulse on each clock where the counters advance.
- `hCount` output 10: horizontal position, 0..H_TOTAL-1 (H_TOTAL = 800).
- `vCount` output 10: vertical position, 0..V_TOTAL-1 (V_TOTAL = 525).
- `bright` output 1: high iff `hCount` < H_VISIBLE and `vCount` < V_VISIBLE.
- `hSync` output 1: active-low horizontal sync.
- `vSync` output 1: active-low vertical sync.
- `frame_start` output 1: one-`clk` pulse when the counters wrap to (0,0).

## Operation
- Divider: counts 0..CLK_DIV-1 on every `clk`. `pixel_tick` is asserted on the clock where the divider wraps.
- `hCount` increments on each tick. At H_TOTAL-1 it wraps to 0, and `vCount` increments in the same tick.
- `vCount` wraps from V_TOTAL-1 to 0 in the same tick as the `hCount` wrap.
- Horizontal regions:
  - visible: 0..639
  - front porch: 640..655
  - sync: 656..751 (`hSync` = 0)
  - back porch: 752..799
- Vertical regions:
  - visible: 0..479
  - front porch: 480..489
  - sync: 490..491 (`vSync` = 0)
  - back porch: 492..524
- `bright`, `hSync` and `vSync` are computed from the next counter values and registered on the same edge as the counters. They therefore always describe the currently presented (`hCount`, `vCount`).
- `frame_start` is asserted for exactly one `clk`, on the edge where the counters become (0,0).
- No other state: the block is a free-running raster with no handshake. Consumers sample outputs on any `clk` and must not assume an output is held for a whole pixel unless they qualify with `pixel_tick`.
- Width rule: the 10-bit counters cover up to 1023. Parameter sets whose H_TOTAL or V_TOTAL exceeds 1024 are unsupported; the implementation asserts this at elaboration.

## Timing
- Reset values, applied asynchronously while `reset` = 0:
  - divider = 0
  - `hCount` = 799, `vCount` = 524
  - `bright` = 0, `hSync` = 1, `vSync` = 1
  - `pixel_tick` = 0, `frame_start` = 0
- First tick is the CLK_DIV-th `clk` edge after `reset` deasserts. On that edge the counters wrap to (0,0), `bright` = 1, and `frame_start` = 1.
- Output latency: zero cycles relative to the counter update. All outputs change on the same edge.
- Pixel period is CLK_DIV `clk` cycles. Line period is 800 ticks (3200 clk). Frame period is 420 000 ticks (1 680 000 clk).
- Reset mid-frame: outputs return to reset values immediately, with no partial-frame completion. Restart follows the first-tick rule.
- CLK_DIV = 1: `pixel_tick` is constantly 1 after reset release, and the counters advance every `clk`.

## Structure
- Shared package `vga_timing_pkg` holds:
  - default segment constants
  - derived H_TOTAL / V_TOTAL and the sync start/end constants
  - the counter width (10)
- `vga_bitchange` and future overlay stages reuse the package for visible-area bounds.
- Sub-module `pixel_tick_gen`: parameterised CLK_DIV clock-enable divider with async active-low reset, producing `pixel_tick`.
- Everything else (counters, region decode, output registers) stays in `vga_timing_gen`.

## Test plan
- **Reset release:** hold `reset` = 0 for 10 clk, then release.
  - Outputs hold (799, 524, `bright` = 0, `hSync` = 1, `vSync` = 1) for 3 clk.
  - On the 4th edge: `hCount` = 0, `vCount` = 0, `bright` = 1, `frame_start` = 1 for exactly 1 clk.
- **Horizontal sync:** run one line.
  - `hSync` = 0 exactly for `hCount` 656..751 (96 ticks, 384 clk).
  - `bright` falls when `hCount` = 640.
  - `vCount` increments exactly when `hCount` goes 799→0.
- **Vertical sync and frame:** run one frame.
  - `vSync` = 0 for `vCount` 490..491 (1600 ticks).
  - `bright` = 0 for all of `vCount` 480..524.
  - Next `frame_start` arrives exactly 1 680 000 clk after the previous one.
- **Mid-frame reset:** assert `reset` at `hCount` = 300, `vCount` = 200 for 1 clk.
  - Outputs go to reset values asynchronously, before the next edge.
  - Recovery follows the reset-release scenario.
- **CLK_DIV = 1 build:**
  - `pixel_tick` stays high.
  - Line length is 800 clk and frame length is 420 000 clk.
  - Sync windows are unchanged in count terms.
- **Consistency checker (all scenarios):** on every clk, `bright`/`hSync`/`vSync` equal the region decode of the current (`hCount`, `vCount`).
